sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//   Shares one synchronous single-port SRAM between the IF fetch port and the EX data port of mycpu_core.
//   Grants at most one access per cycle and routes read data back to the owning side after READ_LATENCY cycles.
//   Raises per-side stall requests toward CTRL while a request is held off.
//   Data side has priority; an age counter stops instruction-fetch starvation.
// PARAMETERS
//   ADDR_W        32  address width, both requesters and SRAM
//   DATA_W        32  data width; byte-enable width is DATA_W/8
//   READ_LATENCY  1   SRAM cycles from en to rdata valid; legal values 1..2
//   MAX_WAIT      4   consecutive denied inst cycles before inst takes priority; legal values 1..15
// PORTS
//   clk              in   1         clock, rising edge
//   rst              in   1         reset, asynchronous, active-low
//   inst_req         in   1         fetch request, held until granted
//   inst_addr        in   ADDR_W    fetch address
//   inst_gnt         out  1         fetch accepted this cycle
//   inst_rvalid      out  1         inst_rdata valid this cycle
//   inst_rdata       out  DATA_W    fetch data
//   data_req         in   1         load/store request, held until granted
//   data_wen         in   DATA_W/8  byte write enables; 0 means read
//   data_addr        in   ADDR_W    load/store address
//   data_wdata       in   DATA_W    store data
//   data_gnt         out  1         load/store accepted this cycle
//   data_rvalid      out  1         data_rdata valid (loads only)
//   data_rdata       out  DATA_W    load data
//   sram_en          out  1         SRAM access enable
//   sram_wen         out  DATA_W/8  SRAM byte write enables
//   sram_addr        out  ADDR_W    SRAM address
//   sram_wdata       out  DATA_W    SRAM write data
//   sram_rdata       in   DATA_W    SRAM read data, READ_LATENCY after en
//   stallreq_inst    out  1         inst_req & ~inst_gnt
//   stallreq_data    out  1         data_req & ~data_gnt
// BEHAVIOUR
//   Reset (rst=0): all outputs 0, wait counter 0, in-flight pipe cleared; in-flight reads never return.
//   Grant logic is combinational, same cycle as req; the SRAM command is driven in the grant cycle.
//   inst_prio = (wait_cnt == MAX_WAIT).
//   Both requesting: data wins unless inst_prio, in which case inst wins.
//   One requesting: that side wins. Neither requesting: sram_en=0 and sram_wen/addr/wdata=0.
//   SRAM mux:
//     inst granted -> wen=0, addr=inst_addr, wdata=0
//     data granted -> data_wen, data_addr, data_wdata
//   Exactly one gnt or none per cycle; gnt=0 while rst=0.
//   wait_cnt (4b):
//     inst_req & ~inst_gnt -> +1, saturating at MAX_WAIT
//     inst_gnt or ~inst_req -> 0
//   Return pipe: READ_LATENCY-deep shift register of {valid, owner}.
//     Pushed on every grant with sram_wen==0; data writes push valid=0.
//     At the pipe head: if valid, assert the owner's rvalid for one cycle and pass sram_rdata to that side's rdata.
//   rdata hold: each side's rdata is registered with sram_rdata on its rvalid and keeps that value until that side's next rvalid.
//   Latency: request to rvalid is READ_LATENCY cycles, plus one cycle for every denied cycle.
//   Pipelining: one new grant may be issued every cycle; returns stay in grant order and never collide.
//   Requester rule: addr/wen/wdata stable while req=1 & gnt=0; the arbiter does not check this.
// TESTING
//   1. rst=0 with inst_req=data_req=1 -> all gnt/rvalid/sram_en=0; release rst -> data_gnt=1 in the first cycle.
//   2. Inst read only, addr 0x100, SRAM word 0xDEADBEEF, READ_LATENCY=1:
//      -> inst_gnt same cycle, inst_rvalid next cycle, inst_rdata=0xDEADBEEF, held after.
//   3. Both req continuously, MAX_WAIT=4:
//      -> data_gnt for 4 cycles, inst_gnt in cycle 5, wait_cnt back to 0;
//      -> stallreq_inst high for 4 cycles, stallreq_data high in cycle 5.
//   4. Back-to-back data store (wen=4'hF, 0x200 <- 0x12345678) then data load 0x200:
//      -> no data_rvalid for the store; load returns 0x12345678 after READ_LATENCY cycles.
//   5. READ_LATENCY=2, inst read then data read on consecutive cycles:
//      -> inst_rvalid at t+2 and data_rvalid at t+3, each with the correct word.
//   6. rst asserted one cycle after an inst read grant:
//      -> no inst_rvalid ever appears, inst_rdata=0, pipe empty after release.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one synchronous single-port SRAM between the
// instruction-fetch port and the load/store data port of mycpu_core.
//
// Handshake: each side raises req with a stable address/command and holds it
// until gnt is seen high in the same cycle; gnt=1 means the command is on the
// SRAM bus this cycle. Read data returns on the owner's rvalid exactly
// READ_LATENCY cycles after the grant; writes never return anything.
// Data side wins contention unless fetch has been denied MAX_WAIT cycles in a
// row, after which fetch wins once and its wait count clears.
module sram_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int MAX_WAIT     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_gnt,
  output logic                inst_rvalid,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_gnt,
  output logic                data_rvalid,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_wen,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata,
  output logic                stallreq_inst,
  output logic                stallreq_data
);

  localparam int          BE_W       = DATA_W / 8;
  localparam logic [3:0]  MAX_WAIT_C = 4'(MAX_WAIT);

  // Owner tag carried alongside each in-flight read
  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  logic [3:0]              wait_cnt_q, wait_cnt_d;
  logic                    inst_prio;
  logic                    inst_gnt_c, data_gnt_c;
  logic                    push_vld;
  owner_e                  push_own;
  logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [READ_LATENCY-1:0] pipe_own_q, pipe_own_d;
  logic                    head_vld;
  owner_e                  head_own;
  logic [DATA_W-1:0]       inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0]       data_rdata_q, data_rdata_d;

  assign inst_prio = (wait_cnt_q == MAX_WAIT_C);

  // Grant selection: combinational, at most one side, nothing while in reset
  always_comb begin
    inst_gnt_c = 1'b0;
    data_gnt_c = 1'b0;
    if (rst) begin
      if (inst_req && data_req) begin
        if (inst_prio) inst_gnt_c = 1'b1;
        else           data_gnt_c = 1'b1;
      end else if (inst_req) begin
        inst_gnt_c = 1'b1;
      end else if (data_req) begin
        data_gnt_c = 1'b1;
      end
    end
  end

  assign inst_gnt = inst_gnt_c;
  assign data_gnt = data_gnt_c;

  // Stall requests are suppressed in reset so every output reads 0 there
  assign stallreq_inst = rst & inst_req & ~inst_gnt_c;
  assign stallreq_data = rst & data_req & ~data_gnt_c;

  // SRAM command mux: fetch is always a read, idle bus is all zeros
  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (inst_gnt_c) begin
      sram_en   = 1'b1;
      sram_addr = inst_addr;
    end else if (data_gnt_c) begin
      sram_en    = 1'b1;
      sram_wen   = data_wen;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end
  end

  // Fetch starvation counter: counts denied fetch cycles, saturates at MAX_WAIT
  always_comb begin
    wait_cnt_d = 4'd0;
    if (inst_req && !inst_gnt_c) begin
      wait_cnt_d = inst_prio ? wait_cnt_q : wait_cnt_q + 4'd1;
    end
  end

  // Return pipe shift: a new entry enters at slot 0 every cycle, head is the top slot
  always_comb begin
    push_vld = (inst_gnt_c || data_gnt_c) && (sram_wen == '0);
    push_own = data_gnt_c ? OWN_DATA : OWN_INST;
    pipe_vld_d    = '0;
    pipe_own_d    = '0;
    pipe_vld_d[0] = push_vld;
    pipe_own_d[0] = push_own;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_own_d[i] = pipe_own_q[i-1];
    end
  end

  assign head_vld    = pipe_vld_q[READ_LATENCY-1];
  assign head_own    = owner_e'(pipe_own_q[READ_LATENCY-1]);
  assign inst_rvalid = head_vld && (head_own == OWN_INST);
  assign data_rvalid = head_vld && (head_own == OWN_DATA);

  // Read data: live SRAM word on rvalid, otherwise the last word returned to that side
  always_comb begin
    inst_rdata_d = inst_rvalid ? sram_rdata : inst_rdata_q;
    data_rdata_d = data_rvalid ? sram_rdata : data_rdata_q;
  end

  assign inst_rdata = inst_rdata_d;
  assign data_rdata = data_rdata_d;

  // State registers; reset drops all in-flight reads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q   <= 4'd0;
      pipe_vld_q   <= '0;
      pipe_own_q   <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_own_q   <= pipe_own_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  // BE_W documents the byte-enable width; referenced so the intent stays visible
  logic [BE_W-1:0] unused_be;
  assign unused_be = data_wen & '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter. Two instances: u_dut1 with
// READ_LATENCY=1 and u_dut2 with READ_LATENCY=2, each backed by a small
// behavioural SRAM. Inputs change 1ns after the rising edge, outputs are
// checked 3ns after the rising edge.
module tb_sram_port_arbiter;

  logic        clk;
  logic        rst;

  // instance 1 (READ_LATENCY=1, MAX_WAIT=4)
  logic        i1_req, i1_gnt, i1_rvalid;
  logic [31:0] i1_addr, i1_rdata;
  logic        d1_req, d1_gnt, d1_rvalid;
  logic [3:0]  d1_wen;
  logic [31:0] d1_addr, d1_wdata, d1_rdata;
  logic        s1_en;
  logic [3:0]  s1_wen;
  logic [31:0] s1_addr, s1_wdata, s1_rdata;
  logic        st1_inst, st1_data;

  // instance 2 (READ_LATENCY=2)
  logic        i2_req, i2_gnt, i2_rvalid;
  logic [31:0] i2_addr, i2_rdata;
  logic        d2_req, d2_gnt, d2_rvalid;
  logic [3:0]  d2_wen;
  logic [31:0] d2_addr, d2_wdata, d2_rdata;
  logic        s2_en;
  logic [3:0]  s2_wen;
  logic [31:0] s2_addr, s2_wdata, s2_rdata;
  logic        st2_inst, st2_data;

  int assertions = 0;
  int failures   = 0;

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(1), .MAX_WAIT(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .inst_req(i1_req), .inst_addr(i1_addr), .inst_gnt(i1_gnt),
    .inst_rvalid(i1_rvalid), .inst_rdata(i1_rdata),
    .data_req(d1_req), .data_wen(d1_wen), .data_addr(d1_addr), .data_wdata(d1_wdata),
    .data_gnt(d1_gnt), .data_rvalid(d1_rvalid), .data_rdata(d1_rdata),
    .sram_en(s1_en), .sram_wen(s1_wen), .sram_addr(s1_addr), .sram_wdata(s1_wdata),
    .sram_rdata(s1_rdata),
    .stallreq_inst(st1_inst), .stallreq_data(st1_data)
  );

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(2), .MAX_WAIT(4)) u_dut2 (
    .clk(clk), .rst(rst),
    .inst_req(i2_req), .inst_addr(i2_addr), .inst_gnt(i2_gnt),
    .inst_rvalid(i2_rvalid), .inst_rdata(i2_rdata),
    .data_req(d2_req), .data_wen(d2_wen), .data_addr(d2_addr), .data_wdata(d2_wdata),
    .data_gnt(d2_gnt), .data_rvalid(d2_rvalid), .data_rdata(d2_rdata),
    .sram_en(s2_en), .sram_wen(s2_wen), .sram_addr(s2_addr), .sram_wdata(s2_wdata),
    .sram_rdata(s2_rdata),
    .stallreq_inst(st2_inst), .stallreq_data(st2_data)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural SRAMs, word-indexed by addr[9:2]
  logic [31:0] mem1 [0:255];
  logic [31:0] mem2 [0:255];
  logic [31:0] rd1;
  logic [31:0] rd2_a, rd2_b;

  always @(posedge clk) begin
    if (s1_en) begin
      for (int b = 0; b < 4; b++)
        if (s1_wen[b]) mem1[s1_addr[9:2]][b*8 +: 8] <= s1_wdata[b*8 +: 8];
      rd1 <= mem1[s1_addr[9:2]];
    end
  end
  assign s1_rdata = rd1;

  always @(posedge clk) begin
    if (s2_en) begin
      for (int b = 0; b < 4; b++)
        if (s2_wen[b]) mem2[s2_addr[9:2]][b*8 +: 8] <= s2_wdata[b*8 +: 8];
      rd2_a <= mem2[s2_addr[9:2]];
    end
    rd2_b <= rd2_a;
  end
  assign s2_rdata = rd2_b;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // advance to 1ns after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 32'h0;
      mem2[i] = 32'h0;
    end
    mem1[64]  = 32'hDEADBEEF;  // 0x100
    mem1[192] = 32'hCAFEF00D;  // 0x300
    mem2[64]  = 32'hDEADBEEF;
    mem2[192] = 32'hCAFEF00D;
    rd1 = '0; rd2_a = '0; rd2_b = '0;

    rst = 1'b0;
    i1_req = 0; i1_addr = '0; d1_req = 0; d1_wen = '0; d1_addr = '0; d1_wdata = '0;
    i2_req = 0; i2_addr = '0; d2_req = 0; d2_wen = '0; d2_addr = '0; d2_wdata = '0;

    // ---- 1: reset with both requesting ----
    i1_req = 1; i1_addr = 32'h100; d1_req = 1; d1_addr = 32'h300;
    step(); step();
    settle();
    check("rst_inst_gnt",    i1_gnt,    0);
    check("rst_data_gnt",    d1_gnt,    0);
    check("rst_inst_rvalid", i1_rvalid, 0);
    check("rst_data_rvalid", d1_rvalid, 0);
    check("rst_sram_en",     s1_en,     0);
    check("rst_stall_inst",  st1_inst,  0);
    check("rst_stall_data",  st1_data,  0);
    check("rst_inst_rdata",  i1_rdata,  0);
    step();
    rst = 1'b1;
    settle();
    check("rel_data_gnt",   d1_gnt,   1);
    check("rel_inst_gnt",   i1_gnt,   0);
    check("rel_sram_en",    s1_en,    1);
    check("rel_sram_addr",  s1_addr,  32'h300);
    check("rel_stall_inst", st1_inst, 1);
    check("rel_stall_data", st1_data, 0);
    step();
    i1_req = 0; d1_req = 0;
    settle();
    check("rel_data_rvalid", d1_rvalid, 1);
    check("rel_data_rdata",  d1_rdata,  32'hCAFEF00D);
    check("idle_sram_en",    s1_en,     0);
    check("idle_sram_addr",  s1_addr,   0);
    step();
    settle();
    check("rel_data_rvalid_off", d1_rvalid, 0);
    check("rel_data_rdata_hold", d1_rdata,  32'hCAFEF00D);

    // ---- 2: single fetch read ----
    step();
    i1_req = 1; i1_addr = 32'h100;
    settle();
    check("t2_inst_gnt",  i1_gnt,  1);
    check("t2_sram_addr", s1_addr, 32'h100);
    check("t2_sram_wen",  s1_wen,  0);
    check("t2_rvalid_early", i1_rvalid, 0);
    step();
    i1_req = 0;
    settle();
    check("t2_inst_rvalid", i1_rvalid, 1);
    check("t2_inst_rdata",  i1_rdata,  32'hDEADBEEF);
    step();
    settle();
    check("t2_rvalid_off",  i1_rvalid, 0);
    check("t2_rdata_hold",  i1_rdata,  32'hDEADBEEF);

    // ---- 3: contention, fetch gets through after 4 denied cycles ----
    step();
    i1_req = 1; i1_addr = 32'h100; d1_req = 1; d1_wen = '0; d1_addr = 32'h300;
    for (int c = 1; c <= 6; c++) begin
      settle();
      if (c == 5) begin
        check("t3_inst_gnt_c5",   i1_gnt,   1);
        check("t3_data_gnt_c5",   d1_gnt,   0);
        check("t3_stall_data_c5", st1_data, 1);
        check("t3_stall_inst_c5", st1_inst, 0);
        check("t3_sram_addr_c5",  s1_addr,  32'h100);
      end else begin
        check($sformatf("t3_data_gnt_c%0d", c),   d1_gnt,   1);
        check($sformatf("t3_inst_gnt_c%0d", c),   i1_gnt,   0);
        check($sformatf("t3_stall_inst_c%0d", c), st1_inst, 1);
        check($sformatf("t3_stall_data_c%0d", c), st1_data, 0);
      end
      if (c >= 2 && c <= 5) check($sformatf("t3_data_rvalid_c%0d", c), d1_rvalid, 1);
      if (c == 6) begin
        check("t3_inst_rvalid_c6", i1_rvalid, 1);
        check("t3_inst_rdata_c6",  i1_rdata,  32'hDEADBEEF);
        check("t3_data_rvalid_c6", d1_rvalid, 0);
      end
      step();
    end
    i1_req = 0; d1_req = 0;
    settle();
    check("t3_data_rvalid_tail", d1_rvalid, 1);
    check("t3_data_rdata_tail",  d1_rdata,  32'hCAFEF00D);

    // ---- 4: store then load same address ----
    step();
    d1_req = 1; d1_wen = 4'hF; d1_addr = 32'h200; d1_wdata = 32'h12345678;
    settle();
    check("t4_store_gnt",   d1_gnt,   1);
    check("t4_sram_wen",    s1_wen,   4'hF);
    check("t4_sram_wdata",  s1_wdata, 32'h12345678);
    step();
    d1_wen = 4'h0; d1_wdata = '0;
    settle();
    check("t4_load_gnt",          d1_gnt,    1);
    check("t4_no_store_rvalid",   d1_rvalid, 0);
    check("t4_load_sram_wen",     s1_wen,    0);
    step();
    d1_req = 0;
    settle();
    check("t4_load_rvalid", d1_rvalid, 1);
    check("t4_load_rdata",  d1_rdata,  32'h12345678);
    step();
    settle();
    check("t4_rvalid_off",  d1_rvalid, 0);

    // ---- 5: READ_LATENCY=2, fetch then load back to back ----
    step();
    i2_req = 1; i2_addr = 32'h100;
    settle();
    check("t5_inst_gnt", i2_gnt, 1);
    step();
    i2_req = 0; d2_req = 1; d2_wen = '0; d2_addr = 32'h300;
    settle();
    check("t5_data_gnt",        d2_gnt,    1);
    check("t5_inst_rvalid_t1",  i2_rvalid, 0);
    step();
    d2_req = 0;
    settle();
    check("t5_inst_rvalid_t2",  i2_rvalid, 1);
    check("t5_inst_rdata_t2",   i2_rdata,  32'hDEADBEEF);
    check("t5_data_rvalid_t2",  d2_rvalid, 0);
    step();
    settle();
    check("t5_data_rvalid_t3",  d2_rvalid, 1);
    check("t5_data_rdata_t3",   d2_rdata,  32'hCAFEF00D);
    check("t5_inst_rvalid_t3",  i2_rvalid, 0);

    // ---- 6: reset while a fetch read is in flight ----
    step();
    i1_req = 1; i1_addr = 32'h100;
    settle();
    check("t6_inst_gnt", i1_gnt, 1);
    step();
    i1_req = 0; rst = 1'b0;
    settle();
    check("t6_rvalid_in_rst", i1_rvalid, 0);
    check("t6_rdata_in_rst",  i1_rdata,  0);
    check("t6_data_rdata_in_rst", d1_rdata, 0);
    step();
    rst = 1'b1;
    settle();
    check("t6_rvalid_rel",  i1_rvalid, 0);
    check("t6_sram_en_rel", s1_en,     0);
    step();
    settle();
    check("t6_rvalid_after", i1_rvalid, 0);
    check("t6_rdata_after",  i1_rdata,  0);
    check("t6_drvalid_after", d1_rvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
